// File: rtl/dpc_pkg.sv
// Shared types and constants for the defect-pixel-correction blocks:
// list-buffer state encoding, coordinate width and read-word field offsets.
package dpc_pkg;

   localparam int DPC_COORD_WIDTH = 10;

   localparam int RD_WORD_W  = 32;
   localparam int RD_VLD_BIT = 31;
   localparam int RD_Y_LSB   = 16;
   localparam int RD_X_LSB   = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } bp_state_t;

endpackage

// File: rtl/bp_list_ram.sv
// Simple dual-port list RAM: one write port, one registered read port (1-cycle latency).
// No backpressure; reads and writes are accepted every cycle, read-before-write on collision.
module bp_list_ram #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 20
) (
   input  logic              S_AXI_ACLK,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge S_AXI_ACLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/bp_list_buffer.sv
// Captures per-frame bad-pixel reports into a list RAM with a saturating count; readback has 1-cycle latency.
// No backpressure: reports beyond capacity are dropped and flagged sticky; BP_DEDUP_EN drops repeats of the last stored entry.
module bp_list_buffer
   import dpc_pkg::*;
#(
   parameter int LUT_INDEX_WIDTH = 8,
   parameter int LUT_INDEX_NUM   = 128,
   parameter int COORD_WIDTH     = DPC_COORD_WIDTH
) (
   input  logic                       S_AXI_ACLK,
   input  logic                       S_AXI_ARESETN,
   input  logic                       go,
   input  logic                       frame_start,
   input  logic                       frame_end,
   input  logic                       bp_valid,
   input  logic [COORD_WIDTH-1:0]     bp_x,
   input  logic [COORD_WIDTH-1:0]     bp_y,
   output logic                       frame_detection_done,
   output logic [LUT_INDEX_WIDTH:0]   detected_bp_count,
   output logic                       bp_overflow,
   input  logic [LUT_INDEX_WIDTH-1:0] auto_bp_read_addr,
   output logic [RD_WORD_W-1:0]       auto_bp_read_data
);

   localparam int CNT_W  = LUT_INDEX_WIDTH + 1;
   localparam int RAM_AW = (LUT_INDEX_NUM > 1) ? $clog2(LUT_INDEX_NUM) : 1;
   localparam int DAT_W  = 2 * COORD_WIDTH;

   bp_state_t         state;
   logic              full;
   logic              dup;
   logic              wr_en;
   logic [RAM_AW-1:0] wr_addr;
   logic [DAT_W-1:0]  rd_dat;
   logic              rd_vld_q;

   assign full = detected_bp_count >= CNT_W'(LUT_INDEX_NUM);

`ifdef BP_DEDUP_EN
   logic             last_vld;
   logic [DAT_W-1:0] last_dat;

   // A restart begins a new frame, so its coincident report is never a duplicate.
   assign dup = last_vld && !frame_start && (last_dat == {bp_y, bp_x});

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         last_vld <= 1'b0;
         last_dat <= '0;
      end else if (wr_en) begin
         last_vld <= 1'b1;
         last_dat <= {bp_y, bp_x};
      end else if (go && frame_start && state != ST_IDLE) begin
         last_vld <= 1'b0;
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign wr_en   = go && (state == ST_CAPTURE) && bp_valid && (frame_start || (!full && !dup));
   assign wr_addr = frame_start ? '0 : detected_bp_count[RAM_AW-1:0];

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state                <= ST_IDLE;
         detected_bp_count    <= '0;
         frame_detection_done <= 1'b0;
         bp_overflow          <= 1'b0;
      end else if (!go) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state <= ST_ARMED;
            ST_ARMED, ST_DONE: begin
               if (frame_start) begin
                  state                <= ST_CAPTURE;
                  detected_bp_count    <= '0;
                  frame_detection_done <= 1'b0;
                  bp_overflow          <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (frame_start) begin
                  detected_bp_count    <= wr_en ? CNT_W'(1) : '0;
                  frame_detection_done <= 1'b0;
                  bp_overflow          <= 1'b0;
               end else begin
                  if (wr_en) begin
                     detected_bp_count <= detected_bp_count + CNT_W'(1);
                  end
                  if (bp_valid && full && !dup) begin
                     bp_overflow <= 1'b1;
                  end
                  // A report coinciding with frame_end is still written above.
                  if (frame_end) begin
                     state                <= ST_DONE;
                     frame_detection_done <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= {1'b0, auto_bp_read_addr} < detected_bp_count;
      end
   end

   always_comb begin
      auto_bp_read_data = '0;
      if (rd_vld_q) begin
         auto_bp_read_data[RD_VLD_BIT]                = 1'b1;
         auto_bp_read_data[RD_Y_LSB +: COORD_WIDTH]   = rd_dat[DAT_W-1:COORD_WIDTH];
         auto_bp_read_data[RD_X_LSB +: COORD_WIDTH]   = rd_dat[COORD_WIDTH-1:0];
      end
   end

   bp_list_ram #(
      .DEPTH  (LUT_INDEX_NUM),
      .ADDR_W (RAM_AW),
      .DATA_W (DAT_W)
   ) u_ram (
      .S_AXI_ACLK (S_AXI_ACLK),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_dat     ({bp_y, bp_x}),
      .rd_addr    (auto_bp_read_addr[RAM_AW-1:0]),
      .rd_dat     (rd_dat)
   );

endmodule

// File: tb/tb_bp_list_buffer.sv
// Directed bench for bp_list_buffer: per-cycle vector table plus hand sequences
// for readback, overflow, restart and asynchronous reset.
module tb_bp_list_buffer;

   logic        S_AXI_ACLK = 1'b0;
   logic        S_AXI_ARESETN;
   logic        go, frame_start, frame_end, bp_valid;
   logic [9:0]  bp_x, bp_y;
   logic        frame_detection_done;
   logic [8:0]  detected_bp_count;
   logic        bp_overflow;
   logic [7:0]  auto_bp_read_addr;
   logic [31:0] auto_bp_read_data;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef BP_DEDUP_EN
   localparam int DD = 1;
`else
   localparam int DD = 0;
`endif

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   bp_list_buffer dut (
      .S_AXI_ACLK           (S_AXI_ACLK),
      .S_AXI_ARESETN        (S_AXI_ARESETN),
      .go                   (go),
      .frame_start          (frame_start),
      .frame_end            (frame_end),
      .bp_valid             (bp_valid),
      .bp_x                 (bp_x),
      .bp_y                 (bp_y),
      .frame_detection_done (frame_detection_done),
      .detected_bp_count    (detected_bp_count),
      .bp_overflow          (bp_overflow),
      .auto_bp_read_addr    (auto_bp_read_addr),
      .auto_bp_read_data    (auto_bp_read_data)
   );

   typedef struct {
      logic       go, fs, fe, bv;
      logic [9:0] x, y;
      int         cnt;
      logic       done, ovf;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic g, input logic fs, input logic fe, input logic bv,
                        input logic [9:0] x, input logic [9:0] y);
      go = g; frame_start = fs; frame_end = fe; bp_valid = bv; bp_x = x; bp_y = y;
      @(posedge S_AXI_ACLK);
      #1;
      frame_start = 1'b0; frame_end = 1'b0; bp_valid = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
      auto_bp_read_addr = addr;
      @(posedge S_AXI_ACLK);
      #1;
      check(name, auto_bp_read_data, exp);
   endtask

   initial begin
      S_AXI_ARESETN = 1'b0;
      go = 0; frame_start = 0; frame_end = 0; bp_valid = 0; bp_x = 0; bp_y = 0;
      auto_bp_read_addr = 0;

      //           go fs fe bv  x    y    cnt     done ovf
      vecs[0]  = '{0, 0, 0, 0, 0,   0,   0,      0,   0};
      vecs[1]  = '{1, 0, 0, 0, 0,   0,   0,      0,   0};
      vecs[2]  = '{1, 0, 0, 1, 1,   1,   0,      0,   0};  // ARMED ignores reports
      vecs[3]  = '{1, 1, 0, 0, 0,   0,   0,      0,   0};
      vecs[4]  = '{1, 0, 0, 1, 5,   7,   1,      0,   0};
      vecs[5]  = '{1, 0, 0, 1, 100, 3,   2,      0,   0};
      vecs[6]  = '{1, 0, 0, 0, 0,   0,   2,      0,   0};
      vecs[7]  = '{1, 0, 0, 1, 639, 479, 3,      0,   0};
      vecs[8]  = '{1, 0, 1, 0, 0,   0,   3,      1,   0};
      vecs[9]  = '{1, 0, 0, 1, 1,   2,   3,      1,   0};  // DONE ignores reports
      vecs[10] = '{1, 1, 0, 1, 9,   9,   0,      0,   0};  // DONE->CAPTURE, report ignored
      vecs[11] = '{1, 0, 0, 1, 4,   4,   1,      0,   0};
      vecs[12] = '{1, 0, 0, 1, 4,   4,   2-DD,   0,   0};
      vecs[13] = '{1, 0, 0, 1, 5,   4,   3-DD,   0,   0};
      vecs[14] = '{1, 0, 0, 1, 1,   1,   4-DD,   0,   0};
      vecs[15] = '{1, 0, 1, 1, 9,   9,   5-DD,   1,   0};  // report with frame_end kept
      vecs[16] = '{0, 0, 0, 0, 0,   0,   5-DD,   1,   0};
      vecs[17] = '{0, 1, 0, 1, 3,   3,   5-DD,   1,   0};  // go low holds everything

      repeat (3) @(posedge S_AXI_ACLK);
      #1;
      check("reset_count", 32'(detected_bp_count), 32'd0);
      check("reset_done", 32'(frame_detection_done), 32'd0);
      check("reset_ovf", 32'(bp_overflow), 32'd0);
      check("reset_rdata", auto_bp_read_data, 32'd0);
      @(negedge S_AXI_ACLK);
      S_AXI_ARESETN = 1'b1;

      // Vectors 0-9, then readback of the first frame.
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].go, vecs[i].fs, vecs[i].fe, vecs[i].bv, vecs[i].x, vecs[i].y);
         check($sformatf("v%0d_count", i), 32'(detected_bp_count), 32'(vecs[i].cnt));
         check($sformatf("v%0d_done", i), 32'(frame_detection_done), 32'(vecs[i].done));
         check($sformatf("v%0d_ovf", i), 32'(bp_overflow), 32'(vecs[i].ovf));
      end
      read_chk("rd0", 8'd0, 32'h8007_0005);
      read_chk("rd1", 8'd1, 32'h8003_0064);
      read_chk("rd2", 8'd2, 32'h81DF_027F);
      read_chk("rd3_invalid", 8'd3, 32'h0000_0000);

      for (int i = 10; i < 18; i++) begin
         drive(vecs[i].go, vecs[i].fs, vecs[i].fe, vecs[i].bv, vecs[i].x, vecs[i].y);
         check($sformatf("v%0d_count", i), 32'(detected_bp_count), 32'(vecs[i].cnt));
         check($sformatf("v%0d_done", i), 32'(frame_detection_done), 32'(vecs[i].done));
         check($sformatf("v%0d_ovf", i), 32'(bp_overflow), 32'(vecs[i].ovf));
      end
      read_chk("rd_fe_entry", 8'(4 - DD), 32'h8009_0009);
      read_chk("rd_dedup_e1", 8'd1, (DD != 0) ? 32'h8004_0005 : 32'h8004_0004);

      // Overflow: 130 reports into a 128-entry list.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);
      check("ovf_start_count", 32'(detected_bp_count), 32'd0);
      check("ovf_start_done", 32'(frame_detection_done), 32'd0);
      for (int i = 0; i < 130; i++) begin
         drive(1, 0, 0, 1, 10'(i), 10'(i + 1));
         if (i == 127) begin
            check("full_count", 32'(detected_bp_count), 32'd128);
            check("full_no_ovf", 32'(bp_overflow), 32'd0);
         end
      end
      check("ovf_count", 32'(detected_bp_count), 32'd128);
      check("ovf_flag", 32'(bp_overflow), 32'd1);
      read_chk("rd127", 8'd127, 32'h8080_007F);
      read_chk("rd128_invalid", 8'd128, 32'h0000_0000);
      read_chk("rd255_invalid", 8'd255, 32'h0000_0000);

      // Restart mid-capture clears count and overflow.
      drive(1, 1, 0, 0, 0, 0);
      check("restart_count", 32'(detected_bp_count), 32'd0);
      check("restart_ovf", 32'(bp_overflow), 32'd0);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 10'(20 + i), 10'd1);
      check("pre_restart_count", 32'(detected_bp_count), 32'd4);
      drive(1, 1, 0, 1, 10'd7, 10'd8);
      check("restart_bv_count", 32'(detected_bp_count), 32'd1);
      read_chk("restart_entry0", 8'd0, 32'h8008_0007);
      read_chk("restart_entry1_invalid", 8'd1, 32'h0000_0000);

      // Asynchronous reset mid-capture.
      drive(1, 0, 0, 1, 10'd2, 10'd2);
      auto_bp_read_addr = 8'd0;
      @(posedge S_AXI_ACLK);
      #1;
      check("pre_reset_rdata", auto_bp_read_data, 32'h8008_0007);
      #2;
      S_AXI_ARESETN = 1'b0;
      #1;
      check("arst_count", 32'(detected_bp_count), 32'd0);
      check("arst_done", 32'(frame_detection_done), 32'd0);
      check("arst_ovf", 32'(bp_overflow), 32'd0);
      check("arst_rdata", auto_bp_read_data, 32'd0);
      @(negedge S_AXI_ACLK);
      S_AXI_ARESETN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 1, 10'(30 + i), 10'd5);
         check($sformatf("post_rst_count%0d", i), 32'(detected_bp_count), 32'd0);
      end
      drive(1, 0, 1, 0, 0, 0);
      check("post_rst_done", 32'(frame_detection_done), 32'd0);
      read_chk("post_rst_rdata", 8'd0, 32'h0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
